// File: rtl/winner_policy_pkg.sv
// rtl/winner_policy_pkg.sv - shared state encoding, address/hop defaults and LFSR tap table
package winner_policy_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DRAW      = 4'd1,
        ST_FETCH_LEN = 4'd2,
        ST_WAIT_LEN  = 4'd3,
        ST_PICK      = 4'd4,
        ST_FETCH_HOP = 4'd5,
        ST_WAIT_HOP  = 4'd6,
        ST_EXPLOIT   = 4'd7,
        ST_DONE      = 4'd8
    } state_e;

    localparam int NO_HOP_DEF    = 100;
    localparam int LEN_ADDR_DEF  = 'h720;
    localparam int LIST_BASE_DEF = 'h710;

    // Right-shifting Galois feedback masks; listed widths give maximal-length sequences.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            4:       lfsr_taps = 32'h0000_000C;
            5:       lfsr_taps = 32'h0000_0014;
            6:       lfsr_taps = 32'h0000_0030;
            7:       lfsr_taps = 32'h0000_0060;
            8:       lfsr_taps = 32'h0000_00B8;
            16:      lfsr_taps = 32'h0000_B400;
            default: lfsr_taps = (32'h1 << (w - 1)) | 32'h1;
        endcase
    endfunction

endpackage

// File: rtl/winner_policy_param_lfsr_rng.sv
// rtl/winner_policy_param_lfsr_rng.sv - free-running Galois LFSR random source
// Ports: clock, reset (async, active-high), rnd (current LFSR state, advances every cycle).
// A zero seed would lock the register, so it is replaced by 1.
module lfsr_rng
    import winner_policy_pkg::*;
#(
    parameter int RNG_WIDTH = 8,
    parameter int LFSR_SEED = 'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [RNG_WIDTH-1:0] rnd
);

    localparam logic [RNG_WIDTH-1:0] SEED_TRUNC = RNG_WIDTH'(LFSR_SEED);
    localparam logic [RNG_WIDTH-1:0] SEED_EFF   =
        (SEED_TRUNC == '0) ? {{(RNG_WIDTH-1){1'b0}}, 1'b1} : SEED_TRUNC;
    localparam logic [RNG_WIDTH-1:0] TAPS       = RNG_WIDTH'(lfsr_taps(RNG_WIDTH));

    logic [RNG_WIDTH-1:0] lfsr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[RNG_WIDTH-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    assign rnd = lfsr_q;

endmodule

// File: rtl/winner_policy_param.sv
// rtl/winner_policy_param.sv - epsilon-greedy next-hop selector for the Q-routing node
// Ports: clock/reset (async, active-high); start request; load_epsilon/epsilon_in/epsilon_step
// control the self-decaying epsilon; mybest/bestvalue/besthop/bestneighbor_id/my_node_id feed
// the exploit test; mem_rd/mem_addr/mem_data read the candidate list (1-cycle read latency);
// nexthop/done/busy/explored/epsilon_out/state report the result.
// Optional: WINNER_POLICY_STATS_EN adds clear_stats, explore_count and exploit_count.
module winner_policy_param
    import winner_policy_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_CAND   = 8,
    parameter int LEN_ADDR   = LEN_ADDR_DEF,
    parameter int LIST_BASE  = LIST_BASE_DEF,
    parameter int RNG_WIDTH  = 8,
    parameter int FRAC_SHIFT = 10,
    parameter int NO_HOP     = NO_HOP_DEF,
    parameter int EPS_RESET  = 128,
    parameter int EPS_MIN    = 8,
    parameter int LFSR_SEED  = 'hA5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  load_epsilon,
    input  logic [RNG_WIDTH-1:0]  epsilon_in,
    input  logic [RNG_WIDTH-1:0]  epsilon_step,
    input  logic [WORD_WIDTH-1:0] mybest,
    input  logic [WORD_WIDTH-1:0] bestvalue,
    input  logic [WORD_WIDTH-1:0] besthop,
    input  logic [WORD_WIDTH-1:0] bestneighbor_id,
    input  logic [WORD_WIDTH-1:0] my_node_id,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_WIDTH-1:0] mem_data,
    output logic [WORD_WIDTH-1:0] nexthop,
    output logic                  done,
    output logic                  busy,
    output logic                  explored,
    output logic [RNG_WIDTH-1:0]  epsilon_out,
    output logic [3:0]            state
`ifdef WINNER_POLICY_STATS_EN
    ,
    input  logic                  clear_stats,
    output logic [15:0]           explore_count,
    output logic [15:0]           exploit_count
`endif
);

    localparam int LEN_W  = $clog2(MAX_CAND + 1);
    localparam int PROD_W = RNG_WIDTH + LEN_W;

    state_e                 state_q;
    logic [WORD_WIDTH-1:0]  mybest_q, bestvalue_q, besthop_q, bestnb_q, myid_q;
    logic [WORD_WIDTH-1:0]  lo_q, hi_q, nexthop_q;
    logic [LEN_W-1:0]       len_q;
    logic [RNG_WIDTH-1:0]   eps_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic                   mem_rd_q, done_q, busy_q, explored_q, xphase_q;

    logic [RNG_WIDTH-1:0]   rnd;
    logic [WORD_WIDTH-1:0]  frac_d, lo_d, hi_d, hop_d;
    logic [WORD_WIDTH:0]    hi_sum_d;
    logic [LEN_W-1:0]       len_d, idx_d;
    logic [PROD_W-1:0]      prod_d;
    logic [RNG_WIDTH:0]     eps_diff_d;
    logic [RNG_WIDTH-1:0]   eps_dec_d;
    logic                   explore_d;

    lfsr_rng #(
        .RNG_WIDTH (RNG_WIDTH),
        .LFSR_SEED (LFSR_SEED)
    ) u_rng (
        .clock (clock),
        .reset (reset),
        .rnd   (rnd)
    );

    always_comb begin
        // Tolerance band around mybest; the upper edge clips at all-ones instead of wrapping.
        frac_d   = mybest_q >> FRAC_SHIFT;
        lo_d     = mybest_q - frac_d;
        hi_sum_d = {1'b0, mybest_q} + {1'b0, frac_d};
        hi_d     = hi_sum_d[WORD_WIDTH] ? '1 : hi_sum_d[WORD_WIDTH-1:0];

        hop_d = WORD_WIDTH'(NO_HOP);
        if (bestvalue_q < lo_q) begin
            hop_d = besthop_q;
        end else if ((bestvalue_q <= hi_q) && (bestnb_q != myid_q)) begin
            hop_d = besthop_q;
        end

        len_d = (mem_data > WORD_WIDTH'(MAX_CAND)) ? LEN_W'(MAX_CAND) : mem_data[LEN_W-1:0];

        // r2 < 2^RNG_WIDTH, so the scaled product's upper bits are always below len.
        prod_d = PROD_W'(rnd) * PROD_W'(len_q);
        idx_d  = prod_d[PROD_W-1:RNG_WIDTH];

        eps_diff_d = {1'b0, eps_q} - {1'b0, epsilon_step};
        eps_dec_d  = (eps_diff_d[RNG_WIDTH] || (eps_diff_d[RNG_WIDTH-1:0] < RNG_WIDTH'(EPS_MIN)))
                   ? RNG_WIDTH'(EPS_MIN) : eps_diff_d[RNG_WIDTH-1:0];

        explore_d = (state_q == ST_DRAW) && (rnd < eps_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mybest_q    <= '0;
            bestvalue_q <= '0;
            besthop_q   <= '0;
            bestnb_q    <= '0;
            myid_q      <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            len_q       <= '0;
            xphase_q    <= 1'b0;
            nexthop_q   <= WORD_WIDTH'(NO_HOP);
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            explored_q  <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            eps_q       <= RNG_WIDTH'(EPS_RESET);
        end else begin
            done_q   <= 1'b0;
            mem_rd_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mybest_q    <= mybest;
                        bestvalue_q <= bestvalue;
                        besthop_q   <= besthop;
                        bestnb_q    <= bestneighbor_id;
                        myid_q      <= my_node_id;
                        busy_q      <= 1'b1;
                        state_q     <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (explore_d) begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= ADDR_WIDTH'(LEN_ADDR);
                        state_q    <= ST_FETCH_LEN;
                    end else begin
                        xphase_q <= 1'b0;
                        state_q  <= ST_EXPLOIT;
                    end
                end
                ST_FETCH_LEN: state_q <= ST_WAIT_LEN;
                ST_WAIT_LEN: begin
                    len_q   <= len_d;
                    state_q <= ST_PICK;
                end
                ST_PICK: begin
                    if (len_q == '0) begin
                        nexthop_q  <= WORD_WIDTH'(NO_HOP);
                        explored_q <= 1'b1;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= ADDR_WIDTH'(LIST_BASE) + ADDR_WIDTH'(idx_d);
                        state_q    <= ST_FETCH_HOP;
                    end
                end
                ST_FETCH_HOP: state_q <= ST_WAIT_HOP;
                ST_WAIT_HOP: begin
                    nexthop_q  <= mem_data;
                    explored_q <= 1'b1;
                    done_q     <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_EXPLOIT: begin
                    // Band edges are registered first so the adder and comparators sit in separate cycles.
                    if (!xphase_q) begin
                        lo_q     <= lo_d;
                        hi_q     <= hi_d;
                        xphase_q <= 1'b1;
                    end else begin
                        nexthop_q  <= hop_d;
                        explored_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase

            // An explicit load overrides the decay that accompanies an explore decision.
            if (load_epsilon) begin
                eps_q <= epsilon_in;
            end else if (explore_d) begin
                eps_q <= eps_dec_d;
            end
        end
    end

`ifdef WINNER_POLICY_STATS_EN
    logic [15:0] explore_cnt_q, exploit_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            explore_cnt_q <= '0;
            exploit_cnt_q <= '0;
        end else if (clear_stats) begin
            explore_cnt_q <= '0;
            exploit_cnt_q <= '0;
        end else if (state_q == ST_DONE) begin
            if (explored_q && (explore_cnt_q != 16'hFFFF)) begin
                explore_cnt_q <= explore_cnt_q + 16'd1;
            end else if (!explored_q && (exploit_cnt_q != 16'hFFFF)) begin
                exploit_cnt_q <= exploit_cnt_q + 16'd1;
            end
        end
    end

    assign explore_count = explore_cnt_q;
    assign exploit_count = exploit_cnt_q;
`endif

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign nexthop     = nexthop_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign explored    = explored_q;
    assign epsilon_out = eps_q;
    assign state       = state_q;

endmodule
